life_grid_renderer: RTL and testbench
=====================================

# life_grid_renderer

Parametrised pixel generator that turns a packed cellular-automaton grid (GRID_W × GRID_H cells, one bit each) into 8-bit RRRGGGBB pixels for the VGA timing core. It sits between the VGA timing generator (blank/vcount/sync) and the top-level colour outputs, replacing the per-pixel divide-based lookup with counters. Over a fixed grid mapping it adds:
- a frame-synchronous grid snapshot (no tearing);
- optional cell-boundary gridlines;
- a blinking cursor cell;
- a border colour outside the grid area;
- pipeline-aligned sync outputs.

## Interface
Parameters:
- GRID_W, 32, cells per row
- GRID_H, 32, cells per column
- CELL_W, 20, pixels per cell horizontally (≥2)
- CELL_H, 15, lines per cell vertically (≥2)
- BLINK_FRAMES, 30, frames per cursor blink half-period (≥1)
- ALIVE_COLOUR, 8'hFF, live-cell colour
- DEAD_COLOUR, 8'h00, dead-cell colour
- GRID_COLOUR, 8'h49, gridline colour
- CURSOR_COLOUR, 8'hE0, cursor colour
- BORDER_COLOUR, 8'h02, colour outside grid area

Ports:
- clk  in  1  pixel clock (25 MHz or 40 MHz domain)
- reset  in  1  synchronous, active-high
- blank_in  in  1  high outside active video
- vcount_in  in  11  current line from timing core, 0-based active lines
- hs_in  in  1  Hsync from timing core
- vs_in  in  1  Vsync from timing core
- grid_pack  in  GRID_W*GRID_H  cell (r,c) = grid_pack[r*GRID_W + c]
- show_grid  in  1  enable gridlines
- cursor_en  in  1  enable cursor
- cursor_x  in  $clog2(GRID_W)  cursor column
- cursor_y  in  $clog2(GRID_H)  cursor row
- pixel  out  8  RRRGGGBB colour
- blank_out, hs_out, vs_out  out  1 each  inputs delayed to align with pixel

## Operation
- Reset: pixel=0, blank_out=1, hs_out=hs_in-inactive level 1, vs_out=1, all counters 0, blink phase 0, snapshot cleared to 0.
- Column tracking: within each active run (blank_in=0), pixel n (0-based) maps to col=n/CELL_W, sub_x=n%CELL_W. Implemented with sub-counter + column counter; no dividers. Both clear on any cycle with blank_in=1.
- Row tracking: active line index = vcount_in; row=vcount_in/CELL_H, sub_y=vcount_in%CELL_H via counters. They advance on each blank_in rising edge (end of active run) and clear on the first active cycle where vcount_in==0.
- Frame start: first active cycle with vcount_in==0. On that cycle:
  - grid_pack is copied into the internal snapshot; all lookups for the frame use the snapshot;
  - the frame counter increments; on reaching BLINK_FRAMES it wraps to 0 and the blink phase toggles.
- Counter saturation: the column counter saturates at GRID_W and the row counter at GRID_H. In the saturated state sub-counters keep running but col/row stay at the limit.
- Pixel priority, per active pixel (highest first):
  1. col≥GRID_W or row≥GRID_H → BORDER_COLOUR
  2. cursor_en & blink phase 1 & col==cursor_x & row==cursor_y → CURSOR_COLOUR
  3. show_grid & (sub_x==0 | sub_y==0) → GRID_COLOUR
  4. snapshot bit set → ALIVE_COLOUR
  5. otherwise → DEAD_COLOUR
- Blanked input cycle → pixel=0 (black).
- cursor_x/cursor_y/show_grid/cursor_en are sampled live (not snapshotted). Out-of-range cursor values never match.
- Reset asserted mid-frame: outputs go to reset values next cycle. Rendering resumes correctly from the next frame start; lines before it render with row counters at 0.

## Timing
- 2-stage pipeline:
  - stage 1 registers the snapshot bit and the border/cursor/grid flags;
  - stage 2 registers the pixel colour.
- Latency from blank_in/vcount_in/hs_in/vs_in to pixel/blank_out/hs_out/vs_out is exactly 2 clk cycles. All outputs stay mutually aligned.
- Snapshot update takes effect for the frame-start pixel itself. grid_pack changes mid-frame are invisible until the next frame start.
- One pixel per clock, no stalls; the block never back-pressures the timing core.

## Test plan
- Defaults, 640×480 stimulus, grid_pack bit 0 and bit 1023 set -> pixels (0..19, lines 0..14) and (620..639, lines 465..479) = 8'hFF, all others 8'h00, each appearing 2 cycles after input.
- CELL_W=16, CELL_H=12, all-ones grid -> columns 512..639 and lines 384..479 = 8'h02, the rest 8'hFF.
- show_grid=1, empty grid -> every pixel with n%20==0 or vcount%15==0 = 8'h49, others 8'h00. show_grid=0 -> all 8'h00.
- cursor_en=1, cursor (3,2), BLINK_FRAMES=2 -> cell pixels 60..79 × lines 30..44 alternate: 8'hE0 on frames 2–3, underlying colour on frames 0–1 and 4–5.
- grid_pack toggled at line 200 -> current frame unchanged; new pattern from next frame's first pixel.
- reset pulsed for 1 cycle at line 100 -> pixel=0, blank_out=1 next cycle. Next frame fully matches the golden image.

Source files
------------

// File: rtl/life_grid_renderer.sv
// Counter-based pixel generator: maps a packed cell grid onto the active video area with gridlines,
// a blinking cursor and a border colour; two-stage pipeline keeps sync outputs aligned with pixel.
module life_grid_renderer #(
    parameter int unsigned GRID_W        = 32,
    parameter int unsigned GRID_H        = 32,
    parameter int unsigned CELL_W        = 20,
    parameter int unsigned CELL_H        = 15,
    parameter int unsigned BLINK_FRAMES  = 30,
    parameter logic [7:0]  ALIVE_COLOUR  = 8'hFF,
    parameter logic [7:0]  DEAD_COLOUR   = 8'h00,
    parameter logic [7:0]  GRID_COLOUR   = 8'h49,
    parameter logic [7:0]  CURSOR_COLOUR = 8'hE0,
    parameter logic [7:0]  BORDER_COLOUR = 8'h02
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       blank_in,
    input  logic [10:0]                vcount_in,
    input  logic                       hs_in,
    input  logic                       vs_in,
    input  logic [GRID_W*GRID_H-1:0]   grid_pack,
    input  logic                       show_grid,
    input  logic                       cursor_en,
    input  logic [$clog2(GRID_W)-1:0]  cursor_x,
    input  logic [$clog2(GRID_H)-1:0]  cursor_y,
    output logic [7:0]                 pixel,
    output logic                       blank_out,
    output logic                       hs_out,
    output logic                       vs_out
);

    localparam int unsigned NCells = GRID_W * GRID_H;
    localparam int unsigned SxW    = $clog2(CELL_W);
    localparam int unsigned SyW    = $clog2(CELL_H);
    localparam int unsigned ColW   = $clog2(GRID_W + 1);
    localparam int unsigned RowW   = $clog2(GRID_H + 1);
    localparam int unsigned FcW    = $clog2(BLINK_FRAMES + 1);
    localparam int unsigned IdxW   = $clog2(NCells);

    localparam logic [ColW-1:0] ColMax  = ColW'(GRID_W);
    localparam logic [RowW-1:0] RowMax  = RowW'(GRID_H);
    localparam logic [SxW-1:0]  SubXEnd = SxW'(CELL_W - 1);
    localparam logic [SyW-1:0]  SubYEnd = SyW'(CELL_H - 1);
    localparam logic [FcW-1:0]  FcEnd   = FcW'(BLINK_FRAMES - 1);

    logic [SxW-1:0]    sub_x_q, sub_x_d;
    logic [ColW-1:0]   col_q, col_d;
    logic [SyW-1:0]    sub_y_q, sub_y_d, sub_y_cur;
    logic [RowW-1:0]   row_q, row_d, row_cur;
    logic              blank_prev_q;
    logic [FcW-1:0]    frame_cnt_q, frame_cnt_d;
    logic              blink_q, blink_d;
    logic              phase_q, phase_d;
    logic [NCells-1:0] snap_q, snap_d;

    logic              frame_start, cur_phase, in_grid;
    logic [NCells-1:0] lookup;
    logic [IdxW-1:0]   cell_idx;
    logic              border_hit, cursor_hit, grid_hit, alive_hit;

    logic       s1_blank_q, s1_hs_q, s1_vs_q;
    logic       s1_border_q, s1_cursor_q, s1_grid_q, s1_alive_q;
    logic [7:0] pixel_d;

    always_comb begin
        frame_start = ~blank_in & blank_prev_q & (vcount_in == '0);
        row_cur     = frame_start ? '0 : row_q;
        sub_y_cur   = frame_start ? '0 : sub_y_q;

        sub_x_d = sub_x_q;
        col_d   = col_q;
        if (blank_in) begin
            sub_x_d = '0;
            col_d   = '0;
        end else if (sub_x_q == SubXEnd) begin
            sub_x_d = '0;
            if (col_q != ColMax) col_d = col_q + ColW'(1);
        end else begin
            sub_x_d = sub_x_q + SxW'(1);
        end

        sub_y_d = sub_y_cur;
        row_d   = row_cur;
        if (blank_in & ~blank_prev_q) begin
            if (sub_y_q == SubYEnd) begin
                sub_y_d = '0;
                if (row_q != RowMax) row_d = row_q + RowW'(1);
            end else begin
                sub_y_d = sub_y_q + SyW'(1);
            end
        end

        // The phase in effect for a frame is the blink state held at its start.
        frame_cnt_d = frame_cnt_q;
        blink_d     = blink_q;
        phase_d     = phase_q;
        snap_d      = snap_q;
        if (frame_start) begin
            snap_d  = grid_pack;
            phase_d = blink_q;
            if (frame_cnt_q == FcEnd) begin
                frame_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FcW'(1);
            end
        end
        cur_phase = frame_start ? blink_q : phase_q;

        in_grid    = (col_q < ColMax) & (row_cur < RowMax);
        border_hit = ~in_grid;
        cell_idx   = in_grid ? (IdxW'(row_cur) * IdxW'(GRID_W) + IdxW'(col_q)) : '0;
        lookup     = frame_start ? grid_pack : snap_q;
        alive_hit  = lookup[cell_idx];
        cursor_hit = cursor_en & cur_phase & (col_q == ColW'(cursor_x))
                     & (row_cur == RowW'(cursor_y));
        grid_hit   = show_grid & ((sub_x_q == '0) | (sub_y_cur == '0));

        pixel_d = DEAD_COLOUR;
        if (s1_blank_q)       pixel_d = 8'h00;
        else if (s1_border_q) pixel_d = BORDER_COLOUR;
        else if (s1_cursor_q) pixel_d = CURSOR_COLOUR;
        else if (s1_grid_q)   pixel_d = GRID_COLOUR;
        else if (s1_alive_q)  pixel_d = ALIVE_COLOUR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sub_x_q      <= '0;
            col_q        <= '0;
            sub_y_q      <= '0;
            row_q        <= '0;
            blank_prev_q <= 1'b1;
            frame_cnt_q  <= '0;
            blink_q      <= 1'b0;
            phase_q      <= 1'b0;
            snap_q       <= '0;
            s1_blank_q   <= 1'b1;
            s1_hs_q      <= 1'b1;
            s1_vs_q      <= 1'b1;
            s1_border_q  <= 1'b0;
            s1_cursor_q  <= 1'b0;
            s1_grid_q    <= 1'b0;
            s1_alive_q   <= 1'b0;
            pixel        <= 8'h00;
            blank_out    <= 1'b1;
            hs_out       <= 1'b1;
            vs_out       <= 1'b1;
        end else begin
            sub_x_q      <= sub_x_d;
            col_q        <= col_d;
            sub_y_q      <= sub_y_d;
            row_q        <= row_d;
            blank_prev_q <= blank_in;
            frame_cnt_q  <= frame_cnt_d;
            blink_q      <= blink_d;
            phase_q      <= phase_d;
            snap_q       <= snap_d;
            s1_blank_q   <= blank_in;
            s1_hs_q      <= hs_in;
            s1_vs_q      <= vs_in;
            s1_border_q  <= border_hit;
            s1_cursor_q  <= cursor_hit;
            s1_grid_q    <= grid_hit;
            s1_alive_q   <= alive_hit;
            pixel        <= pixel_d;
            blank_out    <= s1_blank_q;
            hs_out       <= s1_hs_q;
            vs_out       <= s1_vs_q;
        end
    end

endmodule

// File: tb/tb_life_grid_renderer.sv
// Directed bench for life_grid_renderer on a reduced 4x4-cell grid of 4x3-pixel cells with a
// 20x14 active area, so the border, blink, snapshot and reset behaviours fit in a few frames.
module tb_life_grid_renderer;

    localparam int GW    = 4;
    localparam int GH    = 4;
    localparam int CW    = 4;
    localparam int CH    = 3;
    localparam int BF    = 2;
    localparam int H_ACT = 20;
    localparam int H_TOT = 24;
    localparam int V_ACT = 14;
    localparam int V_TOT = 16;

    typedef struct packed {
        logic       known;
        logic [7:0] pix;
        logic       blank;
        logic       hs;
        logic       vs;
    } exp_t;

    localparam exp_t ExpReset = '{known: 1'b1, pix: 8'h00, blank: 1'b1, hs: 1'b1, vs: 1'b1};

    logic        clk = 1'b0;
    logic        reset, blank_in, hs_in, vs_in, show_grid, cursor_en;
    logic [10:0] vcount_in;
    logic [15:0] grid_pack;
    logic [1:0]  cursor_x, cursor_y;
    logic [7:0]  pixel;
    logic        blank_out, hs_out, vs_out;

    int   n_checks, n_pass, n_fail;
    exp_t exp_d1, exp_d2;
    logic [15:0] frame_grid;
    int   frame_idx;
    logic pix_valid;

    always #5 clk = ~clk;

    life_grid_renderer #(
        .GRID_W(GW), .GRID_H(GH), .CELL_W(CW), .CELL_H(CH), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .reset(reset), .blank_in(blank_in), .vcount_in(vcount_in),
        .hs_in(hs_in), .vs_in(vs_in), .grid_pack(grid_pack), .show_grid(show_grid),
        .cursor_en(cursor_en), .cursor_x(cursor_x), .cursor_y(cursor_y),
        .pixel(pixel), .blank_out(blank_out), .hs_out(hs_out), .vs_out(vs_out)
    );

    // Reference colour of active pixel (h, v) straight from the priority rules.
    function automatic logic [7:0] model_pixel(int h, int v);
        int col, row;
        logic phase;
        col   = h / CW;
        row   = v / CH;
        phase = (frame_idx >= 0) && (((frame_idx / BF) % 2) == 1);
        if (col >= GW || row >= GH) return 8'h02;
        if (cursor_en && phase && col == int'(cursor_x) && row == int'(cursor_y)) return 8'hE0;
        if (show_grid && ((h % CW) == 0 || (v % CH) == 0)) return 8'h49;
        if (frame_grid[row*GW + col]) return 8'hFF;
        return 8'h00;
    endfunction

    task automatic check_outputs();
        if (exp_d2.known) begin
            n_checks++;
            assert (pixel === exp_d2.pix) n_pass++;
            else begin
                n_fail++;
                $error("FAIL pixel f=%0d obs=%h exp=%h", frame_idx, pixel, exp_d2.pix);
            end
        end
        n_checks++;
        assert (blank_out === exp_d2.blank) n_pass++;
        else begin
            n_fail++;
            $error("FAIL blank_out obs=%b exp=%b", blank_out, exp_d2.blank);
        end
        n_checks++;
        assert (hs_out === exp_d2.hs) n_pass++;
        else begin
            n_fail++;
            $error("FAIL hs_out obs=%b exp=%b", hs_out, exp_d2.hs);
        end
        n_checks++;
        assert (vs_out === exp_d2.vs) n_pass++;
        else begin
            n_fail++;
            $error("FAIL vs_out obs=%b exp=%b", vs_out, exp_d2.vs);
        end
    endtask

    // One clock: check outputs due now, drive new inputs, queue their expected outputs.
    task automatic step(input logic rst, input logic blank, input logic hs, input logic vs,
                        input int h, input int v);
        @(posedge clk);
        #1;
        check_outputs();
        reset     = rst;
        blank_in  = blank;
        hs_in     = hs;
        vs_in     = vs;
        vcount_in = 11'(v);
        exp_d2    = exp_d1;
        if (rst) begin
            exp_d2    = ExpReset;
            exp_d1    = ExpReset;
            pix_valid = 1'b0;
            frame_idx = -1;
        end else begin
            exp_d1 = '{known: pix_valid, pix: (blank ? 8'h00 : model_pixel(h, v)),
                       blank: blank, hs: hs, vs: vs};
        end
    endtask

    task automatic run_frame(input int rst_line, input int chg_line, input logic [15:0] chg_grid);
        for (int v = 0; v < V_TOT; v++) begin
            for (int h = 0; h < H_TOT; h++) begin
                logic blank, hs, vs, rst;
                blank = (h >= H_ACT) || (v >= V_ACT);
                hs    = !((h >= H_ACT + 1) && (h < H_ACT + 3));
                vs    = (v != V_TOT - 1);
                rst   = (v == rst_line) && (h == 3);
                if (v == 0 && h == 0) begin
                    frame_idx++;
                    frame_grid = grid_pack;
                    pix_valid  = 1'b1;
                end
                if (v == chg_line && h == 0) grid_pack = chg_grid;
                step(rst, blank, hs, vs, h, v);
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        n_fail    = 0;
        reset     = 1'b1;
        blank_in  = 1'b1;
        hs_in     = 1'b1;
        vs_in     = 1'b1;
        vcount_in = '0;
        grid_pack = 16'h0000;
        show_grid = 1'b0;
        cursor_en = 1'b0;
        cursor_x  = 2'd3;
        cursor_y  = 2'd2;
        exp_d1    = ExpReset;
        exp_d2    = ExpReset;
        frame_grid = '0;
        frame_idx = -1;
        pix_valid = 1'b0;

        repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1, 0, 0);
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1, 0, V_TOT - 1);

        // Corner cells alive only.
        grid_pack = 16'h8001;
        run_frame(-1, -1, '0);

        // Gridlines over an empty grid.
        grid_pack = 16'h0000;
        show_grid = 1'b1;
        run_frame(-1, -1, '0);

        // Full grid with blinking cursor; snapshot must hide the mid-frame change.
        show_grid = 1'b0;
        cursor_en = 1'b1;
        grid_pack = 16'hFFFF;
        run_frame(-1, -1, '0);
        run_frame(-1, 6, 16'h5A3C);

        // New pattern appears from this frame; reset pulse mid-frame.
        run_frame(5, -1, '0);

        // Rendering and blink restart cleanly after reset.
        grid_pack = 16'h0F0F;
        run_frame(-1, -1, '0);
        show_grid = 1'b1;
        run_frame(-1, -1, '0);
        show_grid = 1'b0;
        run_frame(-1, -1, '0);

        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1, 0, V_TOT - 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
